// File: rtl/fir_coeff_loader_pkg.sv
// ---------------------------------------------------------------------------
// fir_coeff_loader_pkg
//   Shared types, default parameters and the coefficient address map used by
//   the FIR coefficient loader and its shadow bank.
//   Contents:
//     state_e         loader FSM states
//     addr_map_t      {is_pos, addr} result of the address map
//     coeff_addr_map  maps coefficient index k to the pos/neg RAM address
// ---------------------------------------------------------------------------
package fir_coeff_loader_pkg;

  localparam int NUM_COEFF_DEF = 12;
  localparam int DATA_W_DEF    = 16;
  localparam int ADDR_W_DEF    = 4;
  localparam int FLAG_HOLD_DEF = 20;

  // Width of the coefficient counter and of oNumOfCoeff.
  localparam int K_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_SETUP = 3'd2,
    ST_WRITE = 3'd3,
    ST_HOLD  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  typedef struct packed {
    logic           is_pos;
    logic [K_W-1:0] addr;
  } addr_map_t;

  // Odd indices fill the pos RAM from 1 upward, even indices fill the neg RAM,
  // except the last even index, which lands in the pos RAM after the odd ones.
  function automatic addr_map_t coeff_addr_map(input logic [K_W-1:0] k,
                                               input int num_coeff);
    addr_map_t m;
    m.is_pos = 1'b1;
    m.addr   = '0;
    if (k[0]) begin
      m.addr = (k + K_W'(1)) >> 1;
    end else if (int'(k) < num_coeff) begin
      m.is_pos = 1'b0;
      m.addr   = k >> 1;
    end else begin
      m.addr = K_W'(num_coeff / 2 + 1);
    end
    return m;
  endfunction

endpackage

// File: rtl/fir_coeff_loader_shadow_bank.sv
// ---------------------------------------------------------------------------
// fir_coeff_shadow_bank
//   NUM_COEFF x DATA_W register file holding the host's pending coefficients.
//   Entries are indexed 1..NUM_COEFF; other indices neither write nor read.
//   Ports:
//     clk      in   clock
//     clr      in   synchronous clear of all entries
//     wr_en    in   write strobe (already qualified by the caller)
//     wr_idx   in   write index
//     wr_data  in   write data
//     rd_idx   in   asynchronous read index
//     rd_data  out  entry at rd_idx, 0 for an out-of-range index
// ---------------------------------------------------------------------------
module fir_coeff_shadow_bank
  import fir_coeff_loader_pkg::*;
#(
  parameter int NUM_COEFF = NUM_COEFF_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int IDX_W     = 4,
  parameter int RD_W      = K_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [RD_W-1:0]   rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [1:NUM_COEFF];
  logic [DATA_W-1:0] mem_d [1:NUM_COEFF];

  always_comb begin
    for (int i = 1; i <= NUM_COEFF; i++) begin
      mem_d[i] = mem_q[i];
      if (wr_en && (wr_idx == IDX_W'(i))) begin
        mem_d[i] = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 1; i <= NUM_COEFF; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i <= NUM_COEFF; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 1; i <= NUM_COEFF; i++) begin
      if (rd_idx == RD_W'(i)) begin
        rd_data = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/fir_coeff_loader.sv
// ---------------------------------------------------------------------------
// fir_coeff_loader
//   Initiator side of the ReConf_FirFilter coefficient-RAM write port. The
//   host fills a shadow bank, then commits; the loader waits for the next
//   600 kHz sample strobe and replays the bank into the filter's pos/neg RAMs
//   inside one UpdateFlag window.
//   Ports:
//     iClk_12M           in   12 MHz clock
//     iRst               in   synchronous active-high reset
//     iEnSample_600k     in   1-cycle sample strobe
//     iShWr/iShIdx/iShDt in   shadow bank write (index 1..NUM_COEFF)
//     iCommit            in   load request
//     oCoeffiUpdateFlag  out  update window to the filter
//     oCsnRam/oWrnRam    out  RAM chip select / write enable, active low
//     oAddrRam_pos/_neg  out  RAM addresses, 0 when unused
//     oWrDtRam           out  write data
//     oNumOfCoeff        out  coefficient index being written
//     oBusy/oDone/oErr   out  status: busy level, end pulse, reject pulse
// ---------------------------------------------------------------------------
module fir_coeff_loader
  import fir_coeff_loader_pkg::*;
#(
  parameter int NUM_COEFF = NUM_COEFF_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int FLAG_HOLD = FLAG_HOLD_DEF
) (
  input  logic              iClk_12M,
  input  logic              iRst,
  input  logic              iEnSample_600k,
  input  logic              iShWr,
  input  logic [3:0]        iShIdx,
  input  logic [DATA_W-1:0] iShDt,
  input  logic              iCommit,
  output logic              oCoeffiUpdateFlag,
  output logic              oCsnRam,
  output logic              oWrnRam,
  output logic [ADDR_W-1:0] oAddrRam_pos,
  output logic [ADDR_W-1:0] oAddrRam_neg,
  output logic [DATA_W-1:0] oWrDtRam,
  output logic [K_W-1:0]    oNumOfCoeff,
  output logic              oBusy,
  output logic              oDone,
  output logic              oErr
);

  localparam int HOLD_LEN = FLAG_HOLD - NUM_COEFF - 1;
  localparam int HOLD_W   = $clog2(FLAG_HOLD + 1);

  localparam logic [3:0]        MAX_IDX   = 4'(NUM_COEFF);
  localparam logic [K_W-1:0]    LAST_K    = K_W'(NUM_COEFF);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_LEN);

  state_e              state_q, state_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;

  logic                flag_q, flag_d;
  logic                csn_q, csn_d;
  logic                wrn_q, wrn_d;
  logic [ADDR_W-1:0]   addr_pos_q, addr_pos_d;
  logic [ADDR_W-1:0]   addr_neg_q, addr_neg_d;
  logic [DATA_W-1:0]   wr_dt_q, wr_dt_d;
  logic [K_W-1:0]      num_q, num_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                idx_legal;
  logic                sh_wr_ok;
  logic                commit_ok;
  logic [DATA_W-1:0]   shadow_rd;
  addr_map_t           k_map;

  assign idx_legal = (iShIdx != 4'd0) && (iShIdx <= MAX_IDX);
  assign sh_wr_ok  = iShWr && !busy_q && idx_legal;
  assign commit_ok = iCommit && !busy_q;

  // Read port follows the next coefficient index so write data lines up with
  // the registered address and strobes.
  fir_coeff_shadow_bank #(
    .NUM_COEFF (NUM_COEFF),
    .DATA_W    (DATA_W),
    .IDX_W     (4),
    .RD_W      (K_W)
  ) u_shadow_bank (
    .clk     (iClk_12M),
    .clr     (iRst),
    .wr_en   (sh_wr_ok),
    .wr_idx  (iShIdx),
    .wr_data (iShDt),
    .rd_idx  (k_d),
    .rd_data (shadow_rd)
  );

  // Next-state and counters. Both counters saturate at their terminal value,
  // and reaching that value is what ends WRITE and HOLD.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (commit_ok) begin
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        if (iEnSample_600k) begin
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_WRITE;
        k_d     = K_W'(1);
      end
      ST_WRITE: begin
        if (k_q >= LAST_K) begin
          hold_d  = HOLD_W'(1);
          state_d = (HOLD_LEN > 0) ? ST_HOLD : ST_DONE;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      ST_HOLD: begin
        if (hold_q >= HOLD_LAST) begin
          state_d = ST_DONE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        k_d     = '0;
        hold_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so every registered output lines
  // up with the state register on the same edge.
  always_comb begin
    flag_d     = 1'b0;
    csn_d      = 1'b1;
    wrn_d      = 1'b1;
    addr_pos_d = '0;
    addr_neg_d = '0;
    wr_dt_d    = '0;
    num_d      = '0;
    done_d     = 1'b0;
    busy_d     = (state_d != ST_IDLE);
    err_d      = (iShWr && (busy_q || !idx_legal)) || (iCommit && busy_q);
    k_map      = coeff_addr_map(k_d, NUM_COEFF);
    case (state_d)
      ST_SETUP: begin
        flag_d = 1'b1;
        csn_d  = 1'b0;
      end
      ST_WRITE: begin
        flag_d  = 1'b1;
        csn_d   = 1'b0;
        wrn_d   = 1'b0;
        wr_dt_d = shadow_rd;
        num_d   = k_d;
        if (k_map.is_pos) begin
          addr_pos_d = ADDR_W'(k_map.addr);
        end else begin
          addr_neg_d = ADDR_W'(k_map.addr);
        end
      end
      ST_HOLD: begin
        flag_d  = 1'b1;
        wr_dt_d = wr_dt_q;
        num_d   = num_q;
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      hold_q     <= '0;
      flag_q     <= 1'b0;
      csn_q      <= 1'b1;
      wrn_q      <= 1'b1;
      addr_pos_q <= '0;
      addr_neg_q <= '0;
      wr_dt_q    <= '0;
      num_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      hold_q     <= hold_d;
      flag_q     <= flag_d;
      csn_q      <= csn_d;
      wrn_q      <= wrn_d;
      addr_pos_q <= addr_pos_d;
      addr_neg_q <= addr_neg_d;
      wr_dt_q    <= wr_dt_d;
      num_q      <= num_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign oCoeffiUpdateFlag = flag_q;
  assign oCsnRam           = csn_q;
  assign oWrnRam           = wrn_q;
  assign oAddrRam_pos      = addr_pos_q;
  assign oAddrRam_neg      = addr_neg_q;
  assign oWrDtRam          = wr_dt_q;
  assign oNumOfCoeff       = num_q;
  assign oBusy             = busy_q;
  assign oDone             = done_q;
  assign oErr              = err_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// ---------------------------------------------------------------------------
// tb_fir_coeff_loader
//   Self-checking bench for fir_coeff_loader. Each accepted commit pushes the
//   twelve expected RAM writes onto a queue; a negedge monitor pops and
//   compares them as the loader writes, and also checks window timing,
//   strobe alignment and status pulses.
// ---------------------------------------------------------------------------
module tb_fir_coeff_loader;

  localparam int NC = 12;

  typedef struct {
    logic [3:0]  pos;
    logic [3:0]  neg;
    logic [15:0] data;
    logic [5:0]  k;
  } wrExp_t;

  logic        clk = 1'b0;
  logic        iRst = 1'b1;
  logic        iEnSample_600k = 1'b0;
  logic        iShWr = 1'b0;
  logic [3:0]  iShIdx = '0;
  logic [15:0] iShDt = '0;
  logic        iCommit = 1'b0;
  logic        oCoeffiUpdateFlag;
  logic        oCsnRam;
  logic        oWrnRam;
  logic [3:0]  oAddrRam_pos;
  logic [3:0]  oAddrRam_neg;
  logic [15:0] oWrDtRam;
  logic [5:0]  oNumOfCoeff;
  logic        oBusy;
  logic        oDone;
  logic        oErr;

  int checkCount = 0;
  int errCount   = 0;
  int errPulses  = 0;
  int doneCnt    = 0;
  int stbCnt     = 0;
  int sinceStb   = 0;
  int flagCnt    = 0;
  int wrnCnt     = 0;
  int armCnt     = 0;
  int expArm     = -1;
  bit flagStarted = 1'b0;
  bit busyPending = 1'b0;

  wrExp_t      expQ[$];
  wrExp_t      mon;
  logic [15:0] shModel [1:NC];
  logic [15:0] posRam  [0:15];
  logic [15:0] negRam  [0:15];
  logic [15:0] t2Vals  [1:NC] = '{16'h0003, 16'h0006, 16'h0007, 16'h000B,
                                  16'h000D, 16'h0013, 16'h0018, 16'h0025,
                                  16'h0030, 16'h0066, 16'h00CE, 16'h01F4};
  logic [15:0] posExp  [1:7]  = '{16'h0003, 16'h0007, 16'h000D, 16'h0018,
                                  16'h0030, 16'h00CE, 16'h01F4};
  logic [15:0] negExp  [1:5]  = '{16'h0006, 16'h000B, 16'h0013, 16'h0025,
                                  16'h0066};

  fir_coeff_loader #(
    .NUM_COEFF (NC),
    .DATA_W    (16),
    .ADDR_W    (4),
    .FLAG_HOLD (20)
  ) dut (
    .iClk_12M          (clk),
    .iRst              (iRst),
    .iEnSample_600k    (iEnSample_600k),
    .iShWr             (iShWr),
    .iShIdx            (iShIdx),
    .iShDt             (iShDt),
    .iCommit           (iCommit),
    .oCoeffiUpdateFlag (oCoeffiUpdateFlag),
    .oCsnRam           (oCsnRam),
    .oWrnRam           (oWrnRam),
    .oAddrRam_pos      (oAddrRam_pos),
    .oAddrRam_neg      (oAddrRam_neg),
    .oWrDtRam          (oWrDtRam),
    .oNumOfCoeff       (oNumOfCoeff),
    .oBusy             (oBusy),
    .oDone             (oDone),
    .oErr              (oErr)
  );

  always #5 clk = ~clk;

  // Free-running sample strobe: one high cycle in every twenty.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      stbCnt = (stbCnt == 19) ? 0 : stbCnt + 1;
      iEnSample_600k = (stbCnt == 0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got busy=%0b required idle", oBusy);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h required %0h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [3:0] idx,
                               input logic [15:0] dt, input logic commit);
    @(posedge clk);
    #1;
    iShWr   = wr;
    iShIdx  = idx;
    iShDt   = dt;
    iCommit = commit;
  endtask

  task automatic writeShadow(input int idx, input logic [15:0] dt);
    applyStimulus(1'b1, 4'(idx), dt, 1'b0);
    shModel[idx] = dt;
  endtask

  task automatic pushLoad();
    wrExp_t e;
    for (int k = 1; k <= NC; k++) begin
      e.k    = 6'(k);
      e.data = shModel[k];
      e.pos  = '0;
      e.neg  = '0;
      if (k % 2 == 1) e.pos = 4'((k + 1) / 2);
      else if (k < NC) e.neg = 4'(k / 2);
      else e.pos = 4'(NC / 2 + 1);
      expQ.push_back(e);
    end
  endtask

  task automatic commitLoad(input int armExp);
    expArm = armExp;
    pushLoad();
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b1);
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b0);
  endtask

  task automatic waitIdle(input int maxCycles);
    int n = 0;
    @(negedge clk);
    while ((oBusy || expQ.size() != 0) && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxCycles) checkOutput("idle_timeout", 32'(n), 32'(0));
  endtask

  task automatic waitWrites(input int num, input int maxCycles);
    int n = 0;
    while (wrnCnt < num && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxCycles) checkOutput("write_timeout", 32'(n), 32'(0));
  endtask

  task automatic waitStbPhase(input int target);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stbCnt != target && n < 50);
    if (n >= 50) checkOutput("strobe_timeout", 32'(n), 32'(0));
  endtask

  // Monitor: scoreboard pop on each RAM write plus per-load timing checks.
  always @(negedge clk) begin
    if (iEnSample_600k) sinceStb = 0;
    else sinceStb++;
    if (iRst) begin
      flagCnt = 0; wrnCnt = 0; armCnt = 0;
      flagStarted = 1'b0; busyPending = 1'b0;
    end else begin
      if (oErr) errPulses++;
      if (oBusy && !oCoeffiUpdateFlag && !oDone && !flagStarted) armCnt++;
      if (oCoeffiUpdateFlag) begin
        if (!flagStarted) begin
          flagStarted = 1'b1;
          checkOutput("setup_csn", 32'(oCsnRam), 32'(0));
          checkOutput("setup_wrn", 32'(oWrnRam), 32'(1));
          if (expArm >= 0) checkOutput("arm_wait", 32'(armCnt), 32'(expArm));
          expArm = -1;
        end
        flagCnt++;
      end
      if (!oWrnRam) begin
        wrnCnt++;
        if (wrnCnt == 1) checkOutput("wr_latency", 32'(sinceStb), 32'(2));
        checkOutput("wr_csn", 32'(oCsnRam), 32'(0));
        checkOutput("wr_flag", 32'(oCoeffiUpdateFlag), 32'(1));
        if (expQ.size() == 0) begin
          checkOutput("unexpected_write", 32'(1), 32'(0));
        end else begin
          mon = expQ.pop_front();
          checkOutput("wr_k", 32'(oNumOfCoeff), 32'(mon.k));
          checkOutput("wr_pos", 32'(oAddrRam_pos), 32'(mon.pos));
          checkOutput("wr_neg", 32'(oAddrRam_neg), 32'(mon.neg));
          checkOutput("wr_data", 32'(oWrDtRam), 32'(mon.data));
        end
        if (oAddrRam_pos != 0) posRam[oAddrRam_pos] = oWrDtRam;
        if (oAddrRam_neg != 0) negRam[oAddrRam_neg] = oWrDtRam;
      end else if (oCoeffiUpdateFlag && wrnCnt > 0) begin
        checkOutput("hold_csn", 32'(oCsnRam), 32'(1));
        checkOutput("hold_addr", 32'({oAddrRam_pos, oAddrRam_neg}), 32'(0));
      end
      if (oDone) begin
        doneCnt++;
        checkOutput("flag_cycles", 32'(flagCnt), 32'(20));
        checkOutput("wrn_cycles", 32'(wrnCnt), 32'(12));
        checkOutput("done_flag", 32'(oCoeffiUpdateFlag), 32'(0));
        checkOutput("busy_in_done", 32'(oBusy), 32'(1));
        flagCnt = 0; wrnCnt = 0; armCnt = 0;
        flagStarted = 1'b0;
        busyPending = 1'b1;
      end else if (busyPending) begin
        checkOutput("busy_after_done", 32'(oBusy), 32'(0));
        busyPending = 1'b0;
      end
    end
  end

  initial begin
    int e0;
    int d0;
    for (int i = 1; i <= NC; i++) shModel[i] = '0;
    for (int i = 0; i < 16; i++) begin
      posRam[i] = '0;
      negRam[i] = '0;
    end

    repeat (3) @(posedge clk);
    #1 iRst = 1'b0;
    @(negedge clk);
    checkOutput("rst_flag", 32'(oCoeffiUpdateFlag), 32'(0));
    checkOutput("rst_csn", 32'(oCsnRam), 32'(1));
    checkOutput("rst_wrn", 32'(oWrnRam), 32'(1));
    checkOutput("rst_addr", 32'({oAddrRam_pos, oAddrRam_neg}), 32'(0));
    checkOutput("rst_wrdt", 32'(oWrDtRam), 32'(0));
    checkOutput("rst_num", 32'(oNumOfCoeff), 32'(0));
    checkOutput("rst_status", 32'({oBusy, oDone, oErr}), 32'(0));

    $display("[TB] nominal load");
    e0 = errPulses;
    for (int i = 1; i <= NC; i++) writeShadow(i, t2Vals[i]);
    commitLoad(-1);
    waitIdle(100);
    checkOutput("legal_wr_no_err", 32'(errPulses - e0), 32'(0));
    for (int i = 1; i <= 7; i++) checkOutput("pos_ram", 32'(posRam[i]), 32'(posExp[i]));
    for (int i = 1; i <= 5; i++) checkOutput("neg_ram", 32'(negRam[i]), 32'(negExp[i]));

    $display("[TB] illegal index");
    e0 = errPulses;
    applyStimulus(1'b1, 4'd0, 16'hFFFF, 1'b0);
    applyStimulus(1'b1, 4'd13, 16'hFFFF, 1'b0);
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("illegal_idx_err", 32'(errPulses - e0), 32'(2));
    commitLoad(-1);
    waitIdle(100);

    $display("[TB] strobe alignment");
    waitStbPhase(14);
    commitLoad(5);
    waitIdle(100);
    waitStbPhase(19);
    commitLoad(20);
    waitIdle(100);

    $display("[TB] busy rejection");
    writeShadow(3, 16'h1234);
    writeShadow(10, 16'h4321);
    e0 = errPulses;
    d0 = doneCnt;
    commitLoad(-1);
    waitWrites(2, 60);
    applyStimulus(1'b1, 4'd3, 16'hBEEF, 1'b0);
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b1);
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b0);
    waitIdle(100);
    repeat (4) @(negedge clk);
    checkOutput("busy_reject_err", 32'(errPulses - e0), 32'(2));
    checkOutput("busy_reject_done", 32'(doneCnt - d0), 32'(1));
    checkOutput("busy_reject_idle", 32'(oBusy), 32'(0));

    $display("[TB] reset mid-load");
    for (int i = 1; i <= NC; i++) writeShadow(i, 16'($urandom_range(1, 16'hFFFF)));
    commitLoad(-1);
    waitWrites(4, 60);
    @(posedge clk);
    #1 iRst = 1'b1;
    expQ.delete();
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_csn", 32'(oCsnRam), 32'(1));
    checkOutput("midrst_flag", 32'(oCoeffiUpdateFlag), 32'(0));
    checkOutput("midrst_wrn", 32'(oWrnRam), 32'(1));
    checkOutput("midrst_busy", 32'(oBusy), 32'(0));
    @(posedge clk);
    @(posedge clk);
    #1 iRst = 1'b0;
    for (int i = 1; i <= NC; i++) shModel[i] = '0;
    writeShadow(1, 16'hA5A5);
    writeShadow(12, 16'h5A5A);
    commitLoad(-1);
    waitIdle(100);

    checkOutput("done_total", 32'(doneCnt), 32'(6));
    checkOutput("queue_empty", 32'(expQ.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
